// File: rtl/alarm_controller_pkg.sv
// Shared constants for the anti-theft alarm controller: state encoding,
// parameter-select codes and the factory default times.
package alarm_controller_pkg;

  // State encoding, also presented on state_code
  localparam logic [2:0] StArmed     = 3'd0;
  localparam logic [2:0] StTriggered = 3'd1;
  localparam logic [2:0] StSound     = 3'd2;
  localparam logic [2:0] StDisarmed  = 3'd3;
  localparam logic [2:0] StWaitClose = 3'd4;
  localparam logic [2:0] StArmDelay  = 3'd5;

  // time_param_sel codes
  localparam logic [1:0] PARAM_ARM    = 2'b00;
  localparam logic [1:0] PARAM_DRIVER = 2'b01;
  localparam logic [1:0] PARAM_PASS   = 2'b10;
  localparam logic [1:0] PARAM_ALARM  = 2'b11;

  // Default times in seconds
  localparam int unsigned T_ARM_DEF    = 6;
  localparam int unsigned T_DRIVER_DEF = 8;
  localparam int unsigned T_PASS_DEF   = 15;
  localparam int unsigned T_ALARM_DEF  = 10;

endpackage

// File: rtl/alarm_controller_if.sv
// Countdown-timer handshake: the controller loads a duration with a
// one-cycle start pulse and watches expired.
interface alarm_controller_if;
  logic [3:0] timer_value;
  logic       start_timer;
  logic       expired;

  modport master (
    output timer_value,
    output start_timer,
    input  expired
  );

  modport slave (
    input  timer_value,
    input  start_timer,
    output expired
  );
endinterface

// File: rtl/alarm_time_params.sv
// Register file for the four programmable alarm times, with
// zero-value restore to default and a combinational read port.
module alarm_time_params
  import alarm_controller_pkg::*;
#(
  parameter int unsigned T_ARM_DEFAULT    = T_ARM_DEF,
  parameter int unsigned T_DRIVER_DEFAULT = T_DRIVER_DEF,
  parameter int unsigned T_PASS_DEFAULT   = T_PASS_DEF,
  parameter int unsigned T_ALARM_DEFAULT  = T_ALARM_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       reprogram,
  input  logic [1:0] time_param_sel,
  input  logic [3:0] time_value,
  input  logic [1:0] rd_sel,
  output logic [3:0] rd_value
);

  localparam logic [3:0] DefArm    = 4'(T_ARM_DEFAULT);
  localparam logic [3:0] DefDriver = 4'(T_DRIVER_DEFAULT);
  localparam logic [3:0] DefPass   = 4'(T_PASS_DEFAULT);
  localparam logic [3:0] DefAlarm  = 4'(T_ALARM_DEFAULT);

  logic [3:0][3:0] times_q;
  logic [3:0]      wr_value;

  // Writing zero means "restore the factory default" for that slot
  always_comb begin
    wr_value = time_value;
    if (time_value == 4'd0) begin
      case (time_param_sel)
        PARAM_ARM:    wr_value = DefArm;
        PARAM_DRIVER: wr_value = DefDriver;
        PARAM_PASS:   wr_value = DefPass;
        default:      wr_value = DefAlarm;
      endcase
    end
  end

  // Parameter storage, loaded with defaults on reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      times_q[PARAM_ARM]    <= DefArm;
      times_q[PARAM_DRIVER] <= DefDriver;
      times_q[PARAM_PASS]   <= DefPass;
      times_q[PARAM_ALARM]  <= DefAlarm;
    end else if (reprogram) begin
      times_q[time_param_sel] <= wr_value;
    end
  end

  assign rd_value = times_q[rd_sel];

endmodule

// File: rtl/alarm_controller.sv
// Alarm main FSM: arms/disarms from ignition and door sensors, drives the
// countdown timer, the siren enable and the blinking status LED.
module alarm_controller
  import alarm_controller_pkg::*;
#(
  parameter int unsigned CLK_HZ           = 100_000_000,
  parameter int unsigned T_ARM_DEFAULT    = T_ARM_DEF,
  parameter int unsigned T_DRIVER_DEFAULT = T_DRIVER_DEF,
  parameter int unsigned T_PASS_DEFAULT   = T_PASS_DEF,
  parameter int unsigned T_ALARM_DEFAULT  = T_ALARM_DEF
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      ignition,
  input  logic                      door_driver,
  input  logic                      door_pass,
  input  logic                      reprogram,
  input  logic [1:0]                time_param_sel,
  input  logic [3:0]                time_value,
  alarm_controller_if.master        timer,
  output logic                      siren_enable,
  output logic                      status_led,
  output logic [2:0]                state_code
);

  localparam int unsigned    CntW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_HZ - 1);

  logic [2:0]      state_q, state_d;
  logic            start_q, start_d;
  logic [3:0]      tval_q, tval_d;
  logic            siren_q, siren_d;
  logic            led_q, led_d;
  logic [CntW-1:0] blink_q, blink_d;
  logic            want_start;
  logic [1:0]      rd_sel;
  logic [3:0]      rd_value;
  logic            exp_seen;
  logic            any_door;

  alarm_time_params #(
    .T_ARM_DEFAULT    (T_ARM_DEFAULT),
    .T_DRIVER_DEFAULT (T_DRIVER_DEFAULT),
    .T_PASS_DEFAULT   (T_PASS_DEFAULT),
    .T_ALARM_DEFAULT  (T_ALARM_DEFAULT)
  ) u_params (
    .clock          (clock),
    .reset          (reset),
    .reprogram      (reprogram),
    .time_param_sel (time_param_sel),
    .time_value     (time_value),
    .rd_sel         (rd_sel),
    .rd_value       (rd_value)
  );

  // The timer loads on the edge ending the pulse, so expired is stale then
  assign exp_seen = timer.expired & ~start_q;
  assign any_door = door_driver | door_pass;

  // Next state, timer start request and parameter read select
  always_comb begin
    state_d    = state_q;
    want_start = 1'b0;
    rd_sel     = PARAM_ARM;
    if (reprogram) begin
      state_d = StArmed;
    end else if (ignition && (state_q != StDisarmed)) begin
      state_d = StDisarmed;
    end else begin
      case (state_q)
        StArmed: begin
          if (door_driver) begin
            state_d    = StTriggered;
            want_start = 1'b1;
            rd_sel     = PARAM_DRIVER;
          end else if (door_pass) begin
            state_d    = StTriggered;
            want_start = 1'b1;
            rd_sel     = PARAM_PASS;
          end
        end
        StTriggered: begin
          if (exp_seen) begin
            state_d    = StSound;
            want_start = 1'b1;
            rd_sel     = PARAM_ALARM;
          end
        end
        StSound: begin
          if (exp_seen) begin
            if (any_door) begin
              want_start = 1'b1;
              rd_sel     = PARAM_ALARM;
            end else begin
              state_d = StArmed;
            end
          end
        end
        StDisarmed: begin
          if (!ignition && door_driver) state_d = StWaitClose;
        end
        StWaitClose: begin
          if (!door_driver) begin
            state_d    = StArmDelay;
            want_start = 1'b1;
            rd_sel     = PARAM_ARM;
          end
        end
        StArmDelay: begin
          // Running timer is abandoned; a fresh start happens on re-close
          if (any_door)      state_d = StWaitClose;
          else if (exp_seen) state_d = StArmed;
        end
        default: state_d = StArmed;
      endcase
    end
  end

  // Registered outputs and blink divider next values
  always_comb begin
    start_d = want_start;
    tval_d  = want_start ? rd_value : tval_q;
    siren_d = (state_d == StSound);
    blink_d = '0;
    led_d   = (state_d == StTriggered) || (state_d == StSound);
    // Blink only while staying in ARMED; entry restarts from LED off
    if ((state_d == StArmed) && (state_q == StArmed)) begin
      if (blink_q == CntMax) begin
        blink_d = '0;
        led_d   = ~led_q;
      end else begin
        blink_d = blink_q + 1'b1;
        led_d   = led_q;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StArmed;
      start_q <= 1'b0;
      tval_q  <= 4'd0;
      siren_q <= 1'b0;
      led_q   <= 1'b0;
      blink_q <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      tval_q  <= tval_d;
      siren_q <= siren_d;
      led_q   <= led_d;
      blink_q <= blink_d;
    end
  end

  assign timer.start_timer = start_q;
  assign timer.timer_value = tval_q;
  assign siren_enable      = siren_q;
  assign status_led        = led_q;
  assign state_code        = state_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Self-checking bench for alarm_controller with CLK_HZ = 10 and a
// behavioural countdown timer (expires value*10 cycles after a load).
module tb_alarm_controller;

  localparam int unsigned ClkHz = 10;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ignition = 1'b0;
  logic       door_driver = 1'b0;
  logic       door_pass = 1'b0;
  logic       reprogram = 1'b0;
  logic [1:0] time_param_sel = 2'b00;
  logic [3:0] time_value = 4'd0;
  logic       siren_enable;
  logic       status_led;
  logic [2:0] state_code;

  int n_checks = 0;
  int n_pass   = 0;
  int tcnt;

  alarm_controller_if tif ();

  alarm_controller #(
    .CLK_HZ (ClkHz)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .ignition       (ignition),
    .door_driver    (door_driver),
    .door_pass      (door_pass),
    .reprogram      (reprogram),
    .time_param_sel (time_param_sel),
    .time_value     (time_value),
    .timer          (tif),
    .siren_enable   (siren_enable),
    .status_led     (status_led),
    .state_code     (state_code)
  );

  always #5 clock = ~clock;

  // Behavioural countdown timer
  always @(posedge clock or negedge reset) begin
    if (!reset)                tcnt <= 0;
    else if (tif.start_timer)  tcnt <= int'(tif.timer_value) * int'(ClkHz);
    else if (tcnt != 0)        tcnt <= tcnt - 1;
  end
  assign tif.expired = (tcnt == 0);

  typedef struct {
    logic       ign;
    logic       drv;
    logic       pas;
    logic       rep;
    logic [1:0] sel;
    logic [3:0] val;
    logic [2:0] st;
    logic       start;
    logic [3:0] tv;
    logic       siren;
    logic       led;
  } vec_t;

  vec_t vecs[28];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] code, input int bound, output int edges);
    edges = 0;
    while (state_code != code && edges < bound) begin
      tick();
      edges++;
    end
  endtask

  task automatic wait_exp(input int bound, output int edges);
    edges = 0;
    while (!(tif.expired && !tif.start_timer) && edges < bound) begin
      tick();
      edges++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic check_outs(input string name, input logic [2:0] st, input logic start,
                            input logic [3:0] tv, input logic siren, input logic led);
    check({name, "_state"}, 32'(state_code), 32'(st));
    check({name, "_start"}, 32'(tif.start_timer), 32'(start));
    check({name, "_tval"}, 32'(tif.timer_value), 32'(tv));
    check({name, "_siren"}, 32'(siren_enable), 32'(siren));
    check({name, "_led"}, 32'(status_led), 32'(led));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int edges;
    int pulses;

    //          ign drv pas rep sel   val    st start tv  siren led
    vecs[0]  = '{0, 0, 0, 0, 2'd0, 4'd0, 3'd0, 0, 4'd0,  0, 0};
    vecs[1]  = '{0, 1, 0, 0, 2'd0, 4'd0, 3'd1, 1, 4'd8,  0, 1};
    vecs[2]  = '{0, 0, 0, 0, 2'd0, 4'd0, 3'd1, 0, 4'd8,  0, 1};
    vecs[3]  = '{1, 0, 0, 0, 2'd0, 4'd0, 3'd3, 0, 4'd8,  0, 0};
    vecs[4]  = '{0, 1, 0, 0, 2'd0, 4'd0, 3'd4, 0, 4'd8,  0, 0};
    vecs[5]  = '{0, 0, 0, 0, 2'd0, 4'd0, 3'd5, 1, 4'd6,  0, 0};
    vecs[6]  = '{0, 0, 1, 0, 2'd0, 4'd0, 3'd4, 0, 4'd6,  0, 0};
    vecs[7]  = '{0, 0, 0, 0, 2'd0, 4'd0, 3'd5, 1, 4'd6,  0, 0};
    vecs[8]  = '{0, 0, 0, 1, 2'd0, 4'd2, 3'd0, 0, 4'd6,  0, 0};
    vecs[9]  = '{0, 1, 1, 0, 2'd0, 4'd0, 3'd1, 1, 4'd8,  0, 1};
    vecs[10] = '{1, 0, 0, 0, 2'd0, 4'd0, 3'd3, 0, 4'd8,  0, 0};
    vecs[11] = '{1, 1, 0, 0, 2'd0, 4'd0, 3'd3, 0, 4'd8,  0, 0};
    vecs[12] = '{0, 1, 0, 0, 2'd0, 4'd0, 3'd4, 0, 4'd8,  0, 0};
    vecs[13] = '{0, 0, 0, 0, 2'd0, 4'd0, 3'd5, 1, 4'd2,  0, 0};
    vecs[14] = '{0, 0, 0, 1, 2'd0, 4'd0, 3'd0, 0, 4'd2,  0, 0};
    vecs[15] = '{0, 0, 0, 1, 2'd1, 4'd3, 3'd0, 0, 4'd2,  0, 0};
    vecs[16] = '{0, 1, 0, 0, 2'd0, 4'd0, 3'd1, 1, 4'd3,  0, 1};
    vecs[17] = '{1, 0, 0, 0, 2'd0, 4'd0, 3'd3, 0, 4'd3,  0, 0};
    vecs[18] = '{0, 1, 0, 0, 2'd0, 4'd0, 3'd4, 0, 4'd3,  0, 0};
    vecs[19] = '{0, 0, 0, 0, 2'd0, 4'd0, 3'd5, 1, 4'd6,  0, 0};
    vecs[20] = '{0, 0, 0, 1, 2'd1, 4'd0, 3'd0, 0, 4'd6,  0, 0};
    vecs[21] = '{0, 1, 0, 1, 2'd1, 4'd5, 3'd0, 0, 4'd6,  0, 0};
    vecs[22] = '{0, 1, 0, 0, 2'd0, 4'd0, 3'd1, 1, 4'd5,  0, 1};
    vecs[23] = '{0, 0, 0, 1, 2'd1, 4'd0, 3'd0, 0, 4'd5,  0, 0};
    vecs[24] = '{0, 1, 0, 0, 2'd0, 4'd0, 3'd1, 1, 4'd8,  0, 1};
    vecs[25] = '{0, 0, 0, 1, 2'd3, 4'd0, 3'd0, 0, 4'd8,  0, 0};
    vecs[26] = '{0, 0, 1, 0, 2'd0, 4'd0, 3'd1, 1, 4'd15, 0, 1};
    vecs[27] = '{1, 0, 0, 0, 2'd0, 4'd0, 3'd3, 0, 4'd15, 0, 0};

    // Reset values, then idle blinking with no timer starts
    tick();
    tick();
    check_outs("in_reset", 3'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    reset = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (tif.start_timer) pulses++;
      if (k == 9 || k == 10 || k == 19 || k == 20 || k == 30)
        check($sformatf("blink_k%0d", k), 32'(status_led), 32'((k / 10) % 2));
    end
    check("idle_pulses", 32'(pulses), 32'd0);
    check("idle_state", 32'(state_code), 32'd0);

    // Single-cycle vector table from a fresh reset
    do_reset();
    foreach (vecs[i]) begin
      ignition       = vecs[i].ign;
      door_driver    = vecs[i].drv;
      door_pass      = vecs[i].pas;
      reprogram      = vecs[i].rep;
      time_param_sel = vecs[i].sel;
      time_value     = vecs[i].val;
      tick();
      check_outs($sformatf("vec%0d", i), vecs[i].st, vecs[i].start, vecs[i].tv,
                 vecs[i].siren, vecs[i].led);
    end
    ignition = 1'b0; door_driver = 1'b0; door_pass = 1'b0;
    reprogram = 1'b1; time_param_sel = 2'd3; time_value = 4'd0;
    tick();
    reprogram = 1'b0;
    check("rearm_state", 32'(state_code), 32'd0);

    // Passenger trigger, full siren cycle, back to ARMED
    door_pass = 1'b1;
    tick();
    door_pass = 1'b0;
    check_outs("pass_trig", 3'd1, 1'b1, 4'd15, 1'b0, 1'b1);
    wait_state(3'd2, 400, edges);
    check("pass_to_sound_edges", 32'(edges), 32'd152);
    check_outs("pass_sound", 3'd2, 1'b1, 4'd10, 1'b1, 1'b1);
    wait_state(3'd0, 300, edges);
    check("sound_to_armed_edges", 32'(edges), 32'd102);
    check_outs("pass_rearmed", 3'd0, 1'b0, 4'd10, 1'b0, 1'b0);

    // Door held open through siren expiry restarts the siren
    door_pass = 1'b1;
    tick();
    wait_state(3'd2, 400, edges);
    check("hold_to_sound_edges", 32'(edges), 32'd152);
    wait_exp(300, edges);
    check("hold_exp_edges", 32'(edges), 32'd101);
    tick();
    check_outs("hold_restart", 3'd2, 1'b1, 4'd10, 1'b1, 1'b1);
    door_pass = 1'b0;
    wait_state(3'd0, 300, edges);
    check("hold_rearm_edges", 32'(edges), 32'd102);

    // Ignition on the same cycle as expired in TRIGGERED
    door_driver = 1'b1;
    tick();
    door_driver = 1'b0;
    check_outs("drv_trig", 3'd1, 1'b1, 4'd8, 1'b0, 1'b1);
    wait_exp(300, edges);
    check("drv_exp_edges", 32'(edges), 32'd81);
    ignition = 1'b1;
    tick();
    check_outs("ign_vs_exp", 3'd3, 1'b0, 4'd8, 1'b0, 1'b0);
    tick();
    check("ign_hold_siren", 32'(siren_enable), 32'd0);

    // Disarm flow through arm delay into ARMED
    ignition = 1'b0;
    door_driver = 1'b1;
    tick();
    check("flow_wait_close", 32'(state_code), 32'd4);
    door_driver = 1'b0;
    tick();
    check_outs("flow_arm_delay", 3'd5, 1'b1, 4'd6, 1'b0, 1'b0);
    wait_state(3'd0, 200, edges);
    check("flow_armed_edges", 32'(edges), 32'd62);

    // Asynchronous reset in the middle of SOUND
    reprogram = 1'b1; time_param_sel = 2'd2; time_value = 4'd1;
    tick();
    reprogram = 1'b0;
    door_pass = 1'b1;
    tick();
    door_pass = 1'b0;
    check("short_pass_tval", 32'(tif.timer_value), 32'd1);
    wait_state(3'd2, 100, edges);
    check("short_to_sound_edges", 32'(edges), 32'd12);
    tick();
    tick();
    check("pre_reset_siren", 32'(siren_enable), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_outs("async_reset", 3'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    reset = 1'b1;
    door_pass = 1'b1;
    tick();
    door_pass = 1'b0;
    check_outs("post_reset_pass", 3'd1, 1'b1, 4'd15, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alarm_controller.md
# alarm_controller

Main state machine of the anti-theft alarm: watches ignition and door sensors and decides when to arm, disarm, trigger and sound the siren. It is the initiator side of the countdown timer interface. It selects a duration, pulses `start_timer` and reacts to `expired`. It drives `siren_enable` toward the siren generator and a status LED. It also holds the four programmable time parameters.

## Interface
Parameters:
- `CLK_HZ`, 100_000_000, clock cycles per second; sets the ARMED blink rate.
- `T_ARM_DEFAULT`, 6, reset value of the arm delay, in seconds.
- `T_DRIVER_DEFAULT`, 8, reset value of the driver-door delay, in seconds.
- `T_PASS_DEFAULT`, 15, reset value of the passenger-door delay, in seconds.
- `T_ALARM_DEFAULT`, 10, reset value of the siren duration, in seconds.

Ports:
- `clock`  in  1  single system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-low; block is in reset while 0.
- `ignition`  in  1  1 = key on.
- `door_driver`  in  1  1 = driver door open.
- `door_pass`  in  1  1 = passenger door open.
- `reprogram`  in  1  single-cycle pulse; stores `time_value` into the selected parameter.
- `time_param_sel`  in  2  parameter select: 00 arm, 01 driver, 10 passenger, 11 alarm.
- `time_value`  in  4  new parameter value, in seconds.
- `expired`  in  1  from the timer; 1 = countdown reached zero.
- `timer_value`  out  4  duration in seconds sent to the timer.
- `start_timer`  out  1  single-cycle load pulse to the timer.
- `siren_enable`  out  1  1 = siren generator active.
- `status_led`  out  1  status indicator.
- `state_code`  out  3  current state encoding, for debug and display.

## Operation
- All inputs are synchronous to `clock` and debounced upstream.
- State encoding:
  - ARMED = 0
  - TRIGGERED = 1
  - SOUND = 2
  - DISARMED = 3
  - WAIT_CLOSE = 4
  - ARM_DELAY = 5
- Codes 6 and 7 are illegal and go to ARMED on the next edge.
- "exp" means `expired` = 1 and `start_timer` = 0. `expired` is ignored while `start_timer` is high, because the timer loads on the edge that ends the pulse.
- Transition priority, highest first: reset, then `reprogram`, then `ignition`, then the per-state rules below.
- `reprogram` = 1, in any state:
  - Go to ARMED; no timer start.
  - Store `time_value` into the parameter chosen by `time_param_sel`.
  - `time_value` = 0 restores that parameter's default.
- `ignition` = 1 in any non-DISARMED state: go to DISARMED; no timer start.
- ARMED:
  - `door_driver` → TRIGGERED, start the timer with the driver delay.
  - Else `door_pass` → TRIGGERED, start the timer with the passenger delay.
  - Driver door wins if both open together.
- TRIGGERED: exp → SOUND, start the timer with the alarm duration.
- SOUND:
  - exp and both doors closed → ARMED.
  - exp and any door open → stay in SOUND, restart the timer with the alarm duration.
- DISARMED: `ignition` = 0 and `door_driver` = 1 → WAIT_CLOSE.
- WAIT_CLOSE: `door_driver` = 0 → ARM_DELAY, start the timer with the arm delay.
- ARM_DELAY:
  - Any door open → WAIT_CLOSE; no timer start. The timer is left running and its result ignored.
  - Otherwise exp → ARMED.
- `siren_enable` = 1 exactly while in SOUND.
- `status_led`:
  - ARMED: toggles every `CLK_HZ` cycles (0.5 Hz). It is 0 on entry to ARMED and the blink counter is cleared.
  - TRIGGERED and SOUND: held at 1.
  - All other states: 0.

## Timing
- Reset values:
  - State ARMED.
  - Parameters at their defaults.
  - `timer_value` = 0, `start_timer` = 0, `siren_enable` = 0, `status_led` = 0, `state_code` = 0.
  - Blink counter = 0.
- All outputs are registered.
- On the edge that enters a state needing a timer start:
  - `timer_value` takes the selected parameter.
  - `start_timer` goes high for exactly that one following cycle.
  - `timer_value` holds until the next start.
- Latency from an input change to a state change is 1 edge.
- Latency from an input change to the start pulse is 1 edge.
- A parameter written by `reprogram` on edge E is used by any start on edge E+1 or later.
- A `reprogram` on the same edge as a start has two effects:
  - The write still happens.
  - The state goes to ARMED and `start_timer` stays 0.
- Reset asserted mid-countdown forces all outputs to their reset values immediately, without waiting for an edge.
- The blink counter is `$clog2(CLK_HZ)` bits wide and wraps to 0 on each toggle.

## Structure
- Shared package holds:
  - State encoding constants.
  - Parameter-select codes (PARAM_ARM, PARAM_DRIVER, PARAM_PASS, PARAM_ALARM).
  - The four default times.
- Sub-module `alarm_time_params` holds:
  - The 4×4-bit register file with reprogram and default-restore logic.
  - A combinational read port selected by the FSM.
- The FSM, start-pulse generation and blink divider live in `alarm_controller`.

## Test plan
Run with `CLK_HZ` = 10 and a behavioral timer model that asserts `expired` value×`CLK_HZ` cycles after a load.
- Reset release, no inputs → `state_code` = 0, blink toggles every 10 cycles, `start_timer` never pulses.
- ARMED, `door_pass` = 1 for 1 cycle → one pulse with `timer_value` = 15; SOUND after 150 cycles with pulse value 10; ARMED after 100 more cycles with doors closed.
- ARMED, both doors opening on the same cycle → `timer_value` = 8 (driver priority).
- TRIGGERED, `ignition` = 1 on the same cycle as `expired` → DISARMED, `siren_enable` stays 0, no pulse.
- Disarm flow: `ignition` 1→0, driver door opens then closes → pulse with value 6. Reopen the door mid-delay → WAIT_CLOSE. Close it → a second pulse with value 6; ARMED after 60 cycles.
- `reprogram` with sel = 01 and value = 3, then trigger with the driver door → pulse value 3. `reprogram` with value = 0 restores 8.
